// File: rtl/fpu_pkg.sv
// Shared FP32 constants and the in-flight tag record used by the multiplier arbiter.
package fpu_pkg;

  localparam int FP32_W  = 32;
  localparam int RM_W    = 3;
  localparam int FLAGS_W = 5;

  localparam logic [RM_W-1:0] RNE = 3'd0;
  localparam logic [RM_W-1:0] RTZ = 3'd1;
  localparam logic [RM_W-1:0] RDN = 3'd2;
  localparam logic [RM_W-1:0] RUP = 3'd3;
  localparam logic [RM_W-1:0] RMM = 3'd4;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Sized for the largest supported requester count (8); narrower ids zero-extend.
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } mul_tag_t;

endpackage

// File: rtl/fp32_mul_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gidx
);

  always_comb begin
    int   j;
    logic found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (en && !found && req[ID_W'(j)]) begin
        found              = 1'b1;
        grant[ID_W'(j)]    = 1'b1;
        gidx               = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/fp32_mul_arbiter.sv
// Shares one non-stalling pipelined FP32 multiplier among NUM_REQ requesters and
// routes each product back to its issuer through a latency-matched tag pipeline.
module fp32_mul_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pause,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_x,
  input  logic [32*NUM_REQ-1:0]   req_y,
  input  logic [3*NUM_REQ-1:0]    req_rm,
  output logic [FP32_W-1:0]       mul_x,
  output logic [FP32_W-1:0]       mul_y,
  output logic [RM_W-1:0]         mul_rm,
  input  logic [FP32_W-1:0]       mul_product,
  input  logic [FLAGS_W-1:0]      mul_flags,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [FP32_W-1:0]       resp_product,
  output logic [FLAGS_W-1:0]      resp_flags,
  output logic                    busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gidx;
  logic [NUM_REQ-1:0] grant;
  logic               hs;
  mul_tag_t           tags [LATENCY];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (!pause && !rst),
    .grant (grant),
    .gidx  (gidx)
  );

  // The arbiter only grants valid requesters, so any grant is a handshake.
  assign req_ready = grant;
  assign hs        = |grant;

  always_comb begin
    mul_x  = '0;
    mul_y  = '0;
    mul_rm = '0;
    if (hs) begin
      mul_x  = req_x[FP32_W*gidx +: FP32_W];
      mul_y  = req_y[FP32_W*gidx +: FP32_W];
      mul_rm = req_rm[RM_W*gidx +: RM_W];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LATENCY; k++) busy = busy | tags[k].v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      resp_valid   <= '0;
      resp_product <= '0;
      resp_flags   <= '0;
      for (int k = 0; k < LATENCY; k++) tags[k] <= '0;
    end else begin
      if (hs) rr_ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      tags[0].v  <= hs;
      tags[0].id <= TAG_ID_W'(gidx);
      for (int k = 1; k < LATENCY; k++) tags[k] <= tags[k-1];
      // Last tag stage lines up with the cycle the multiplier presents its product.
      if (tags[LATENCY-1].v) begin
        resp_valid   <= NUM_REQ'(1) << tags[LATENCY-1].id;
        resp_product <= mul_product;
        resp_flags   <= mul_flags;
      end else begin
        resp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Directed bench for fp32_mul_arbiter with a 3-stage stand-in multiplier.
module tb_fp32_mul_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         pause;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_x, req_y;
  logic [11:0]  req_rm;
  logic [31:0]  mul_x, mul_y, mul_product;
  logic [2:0]   mul_rm;
  logic [4:0]   mul_flags;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_product;
  logic [4:0]   resp_flags;
  logic         busy;

  logic [31:0]  ox [4];
  logic [31:0]  oy [4];
  logic [2:0]   orm [4];
  logic [36:0]  mp [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp32_mul_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .pause        (pause),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_rm       (req_rm),
    .mul_x        (mul_x),
    .mul_y        (mul_y),
    .mul_rm       (mul_rm),
    .mul_product  (mul_product),
    .mul_flags    (mul_flags),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .resp_flags   (resp_flags),
    .busy         (busy)
  );

  always_comb begin
    req_x  = '0;
    req_y  = '0;
    req_rm = '0;
    for (int i = 0; i < 4; i++) begin
      req_x[32*i +: 32] = ox[i];
      req_y[32*i +: 32] = oy[i];
      req_rm[3*i +: 3]  = orm[i];
    end
  end

  // Stand-in multiplier: exact results for the known operand pairs, otherwise a
  // distinctive function of the operands so misrouted products are visible.
  function automatic logic [36:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return {32'h40C0_0000, 5'b00000};
    if (a == 32'h7F80_0000 && b == 32'h0000_0000) return {32'h7FC0_0000, 5'b10000};
    return {a ^ {b[15:0], b[31:16]}, a[4:0] ^ b[4:0] ^ 5'h3};
  endfunction

  always @(posedge clk) begin
    mp[0] <= mul_model(mul_x, mul_y);
    mp[1] <= mp[0];
    mp[2] <= mp[1];
  end
  assign {mul_product, mul_flags} = mp[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    pause     = 1'b0;
    req_valid = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic       pause;
    logic [3:0] valid;
    logic [3:0] ready;
    logic [3:0] rv;
    logic       busy;
  } vec_t;

  vec_t tv [$];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [36:0] exp_resp;
    for (int i = 0; i < 4; i++) begin
      ox[i]  = 32'h3F80_0000 + 32'h11 * i;
      oy[i]  = 32'h4000_0000 + 32'h101 * i;
      orm[i] = 3'(i);
    end
    rst = 1'b1; pause = 1'b0; req_valid = '0;
    tick(); tick();

    // Saturation, drain, then pause with pending requests.
    tv.push_back('{1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 4'hF, 4'h1, 4'h0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 4'hF, 4'h2, 4'h0, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'hF, 4'h4, 4'h0, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'hF, 4'h8, 4'h0, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'hF, 4'h1, 4'h1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'hF, 4'h2, 4'h2, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'hF, 4'h4, 4'h4, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'hF, 4'h8, 4'h8, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'hF, 4'h1, 4'h1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'h0, 4'h0, 4'h2, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'h0, 4'h0, 4'h4, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'h0, 4'h0, 4'h8, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 1'b0});
    tv.push_back('{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 4'h3, 4'h1, 4'h0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 4'h2, 4'h2, 4'h0, 1'b1});
    tv.push_back('{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 1'b1});
    tv.push_back('{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 1'b1});
    tv.push_back('{1'b0, 1'b1, 4'hF, 4'h0, 4'h1, 1'b1});
    tv.push_back('{1'b0, 1'b1, 4'hF, 4'h0, 4'h2, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 4'hF, 4'h4, 4'h0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1});
    tv.push_back('{1'b0, 1'b0, 4'h0, 4'h0, 4'h4, 1'b0});
    tv.push_back('{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0});

    foreach (tv[n]) begin
      rst       = tv[n].rst;
      pause     = tv[n].pause;
      req_valid = tv[n].valid;
      @(negedge clk);
      chk($sformatf("row%0d req_ready", n), 64'(req_ready), 64'(tv[n].ready));
      chk($sformatf("row%0d resp_valid", n), 64'(resp_valid), 64'(tv[n].rv));
      chk($sformatf("row%0d busy", n), 64'(busy), 64'(tv[n].busy));
      for (int i = 0; i < 4; i++) begin
        if (tv[n].rv[i]) begin
          exp_resp = mul_model(ox[i], oy[i]);
          chk($sformatf("row%0d resp_product", n), 64'(resp_product), 64'(exp_resp[36:5]));
          chk($sformatf("row%0d resp_flags", n), 64'(resp_flags), 64'(exp_resp[4:0]));
        end
      end
      tick();
    end
    rst = 1'b0; pause = 1'b0; req_valid = '0;

    // Single request from requester 2: 2.0 * 3.0.
    ox[2] = 32'h4000_0000; oy[2] = 32'h4040_0000; orm[2] = 3'd0;
    do_reset();
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single req_ready", 64'(req_ready), 64'h4);
    chk("single mul_x", 64'(mul_x), 64'h4000_0000);
    chk("single mul_y", 64'(mul_y), 64'h4040_0000);
    chk("single mul_rm", 64'(mul_rm), 64'h0);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("idle mul_x", 64'(mul_x), 64'h0);
    tick(); tick();
    @(negedge clk);
    chk("single early resp_valid", 64'(resp_valid), 64'h0);
    tick();
    @(negedge clk);
    chk("single resp_valid", 64'(resp_valid), 64'h4);
    chk("single resp_product", 64'(resp_product), 64'h40C0_0000);
    chk("single resp_flags", 64'(resp_flags), 64'h0);
    tick();
    @(negedge clk);
    chk("single resp_valid drop", 64'(resp_valid), 64'h0);
    chk("single product hold", 64'(resp_product), 64'h40C0_0000);

    // Special value: inf * 0 from requester 3 with a non-default rounding mode.
    ox[3] = 32'h7F80_0000; oy[3] = 32'h0000_0000; orm[3] = 3'd3;
    do_reset();
    req_valid = 4'b1000;
    @(negedge clk);
    chk("special req_ready", 64'(req_ready), 64'h8);
    chk("special mul_rm", 64'(mul_rm), 64'h3);
    tick();
    req_valid = 4'b0000;
    tick(); tick(); tick();
    @(negedge clk);
    chk("special resp_valid", 64'(resp_valid), 64'h8);
    chk("special resp_product", 64'(resp_product), 64'h7FC0_0000);
    chk("special resp_flags", 64'(resp_flags), 64'h10);

    // Fairness between requesters 1 and 3 starting from pointer 2.
    do_reset();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("fair setup grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("fair grant%0d", c), 64'(req_ready), (c % 2 == 0) ? 64'h8 : 64'h2);
      tick();
    end
    req_valid = 4'b0000;

    // Reset while two operations are in flight.
    do_reset();
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    rst = 1'b1; req_valid = 4'b0000;
    @(negedge clk);
    chk("rst req_ready", 64'(req_ready), 64'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post rst busy", 64'(busy), 64'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("post rst resp_valid%0d", c), 64'(resp_valid), 64'h0);
      tick();
    end
    req_valid = 4'b1010;
    @(negedge clk);
    chk("post rst first grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
